// File: rtl/shift_reg_pkg.sv
// Shared op encoding for the universal shift register family.
package shift_reg_pkg;
  localparam int SHIFT_OP_W = 3;

  typedef enum logic [SHIFT_OP_W-1:0] {
    OP_HOLD  = 3'b000,
    OP_SHL   = 3'b001,
    OP_SHR   = 3'b010,
    OP_ROL   = 3'b011,
    OP_ROR   = 3'b100,
    OP_ASR   = 3'b101,
    OP_LOAD  = 3'b110,
    OP_CLEAR = 3'b111
  } shift_op_e;
endpackage

// File: rtl/shift_frame_cnt.sv
// Frame bit counter: counts shift ops, wraps at WIDTH-1 and pulses frame_done
// for one cycle on the wrap. clr has priority over inc.
module shift_frame_cnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (clr) begin
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (inc) begin
      if (bit_cnt == LAST) begin
        bit_cnt    <= '0;
        frame_done <= 1'b1;
      end else begin
        bit_cnt    <= bit_cnt + 1'b1;
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end
endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate/arith modes, load, clear, frame counter.
// Optional UNIV_SHIFT_REG_PARITY_EN adds a registered XOR-reduce output of q_out.
import shift_reg_pkg::*;

module univ_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [SHIFT_OP_W-1:0] op,
  input  logic                  s_in,
  input  logic [WIDTH-1:0]      d_in,
  output logic [WIDTH-1:0]      q_out,
  output logic                  s_out,
  output logic [CNT_W-1:0]      bit_cnt,
  output logic                  frame_done
`ifdef UNIV_SHIFT_REG_PARITY_EN
  ,
  output logic                  parity
`endif
);
  shift_op_e        op_e;
  logic [WIDTH-1:0] q_next;
  logic             s_next;
  logic             counted;
  logic             restart;

  assign op_e = shift_op_e'(op);

  always_comb begin
    q_next  = q_out;
    s_next  = s_out;
    counted = 1'b0;
    restart = 1'b0;
    if (en) begin
      case (op_e)
        OP_SHL:   begin q_next = {q_out[WIDTH-2:0], s_in};        s_next = q_out[WIDTH-1]; counted = 1'b1; end
        OP_SHR:   begin q_next = {s_in, q_out[WIDTH-1:1]};        s_next = q_out[0];       counted = 1'b1; end
        OP_ROL:   begin q_next = {q_out[WIDTH-2:0], q_out[WIDTH-1]}; s_next = q_out[WIDTH-1]; counted = 1'b1; end
        OP_ROR:   begin q_next = {q_out[0], q_out[WIDTH-1:1]};    s_next = q_out[0];       counted = 1'b1; end
        OP_ASR:   begin q_next = {q_out[WIDTH-1], q_out[WIDTH-1:1]}; s_next = q_out[0];    counted = 1'b1; end
        // LOAD leaves s_out alone; CLEAR zeroes it
        OP_LOAD:  begin q_next = d_in; restart = 1'b1; end
        OP_CLEAR: begin q_next = '0; s_next = 1'b0; restart = 1'b1; end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_out <= '0;
      s_out <= 1'b0;
    end else begin
      q_out <= q_next;
      s_out <= s_next;
    end
  end

`ifdef UNIV_SHIFT_REG_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity <= 1'b0;
    else     parity <= ^q_next;
  end
`endif

  shift_frame_cnt #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc        (counted),
    .clr        (restart),
    .bit_cnt    (bit_cnt),
    .frame_done (frame_done)
  );
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed vector bench for univ_shift_reg: 8-bit table run plus a 4-bit frame check.
`timescale 1ns/1ps
module tb_univ_shift_reg;
  import shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] op = 3'b000;
  logic       s_in = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] q_out;
  logic       s_out;
  logic [2:0] bit_cnt;
  logic       frame_done;

  logic       en4 = 1'b0;
  logic [2:0] op4 = 3'b000;
  logic       s_in4 = 1'b0;
  logic [3:0] d_in4 = 4'h0;
  logic [3:0] q4;
  logic       s4;
  logic [1:0] cnt4;
  logic       done4;

`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic parity, parity4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .s_in(s_in), .d_in(d_in),
    .q_out(q_out), .s_out(s_out), .bit_cnt(bit_cnt), .frame_done(frame_done)
`ifdef UNIV_SHIFT_REG_PARITY_EN
    , .parity(parity)
`endif
  );

  univ_shift_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .op(op4), .s_in(s_in4), .d_in(d_in4),
    .q_out(q4), .s_out(s4), .bit_cnt(cnt4), .frame_done(done4)
`ifdef UNIV_SHIFT_REG_PARITY_EN
    , .parity(parity4)
`endif
  );

  typedef struct {
    logic       en;
    logic [2:0] op;
    logic       s_in;
    logic [7:0] d_in;
    logic [7:0] q;
    logic       s;
    logic [2:0] cnt;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic [2:0] o, input logic si, input logic [7:0] d,
                     input logic [7:0] q, input logic s, input logic [2:0] c, input logic dn);
    vecs.push_back('{e, o, si, d, q, s, c, dn});
  endtask

  // Drive one op, clock it, and sample 1ns after the edge.
  task automatic step8(input logic e, input logic [2:0] o, input logic si, input logic [7:0] d);
    en = e; op = o; s_in = si; d_in = d;
    @(posedge clk); #1;
  endtask

  initial begin
    // Expected values hand-computed from reset state q=00 s=0 cnt=0.
    add(1, OP_LOAD, 0, 8'hA5, 8'hA5, 0, 0, 0);
    add(1, OP_SHR,  0, 8'h00, 8'h52, 1, 1, 0);
    add(1, OP_LOAD, 0, 8'h81, 8'h81, 1, 0, 0);
    add(1, OP_ROL,  0, 8'h00, 8'h03, 1, 1, 0);
    add(1, OP_LOAD, 0, 8'h81, 8'h81, 1, 0, 0);
    add(1, OP_ROR,  0, 8'h00, 8'hC0, 1, 1, 0);
    add(1, OP_LOAD, 0, 8'h80, 8'h80, 1, 0, 0);
    add(1, OP_ASR,  0, 8'h00, 8'hC0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, OP_SHL, 1, 8'h00, 8'hC0, 0, 1, 0);
    add(1, OP_HOLD, 1, 8'h00, 8'hC0, 0, 1, 0);
    add(1, OP_SHL,  1, 8'h00, 8'h81, 1, 2, 0);
    add(1, OP_CLEAR,0, 8'h00, 8'h00, 0, 0, 0);
    add(1, OP_SHL, 1, 0, 8'h01, 0, 1, 0);
    add(1, OP_SHL, 1, 0, 8'h03, 0, 2, 0);
    add(1, OP_SHL, 1, 0, 8'h07, 0, 3, 0);
    add(1, OP_SHL, 1, 0, 8'h0F, 0, 4, 0);
    add(1, OP_SHL, 1, 0, 8'h1F, 0, 5, 0);
    add(1, OP_SHL, 1, 0, 8'h3F, 0, 6, 0);
    add(1, OP_SHL, 1, 0, 8'h7F, 0, 7, 0);
    add(1, OP_SHL, 1, 0, 8'hFF, 0, 0, 1);
    // Second frame straight after, no dead cycle.
    add(1, OP_SHL, 0, 0, 8'hFE, 1, 1, 0);
    add(1, OP_SHL, 0, 0, 8'hFC, 1, 2, 0);
    add(1, OP_SHL, 0, 0, 8'hF8, 1, 3, 0);
    add(1, OP_SHL, 0, 0, 8'hF0, 1, 4, 0);
    add(1, OP_SHL, 0, 0, 8'hE0, 1, 5, 0);
    add(1, OP_SHL, 0, 0, 8'hC0, 1, 6, 0);
    add(1, OP_SHL, 0, 0, 8'h80, 1, 7, 0);
    add(1, OP_SHL, 0, 0, 8'h00, 1, 0, 1);
    // Bring cnt to 7, then LOAD on the would-be completing edge.
    add(1, OP_SHL, 0, 0, 8'h00, 0, 1, 0);
    for (int i = 2; i < 8; i++) add(1, OP_SHL, 0, 0, 8'h00, 0, 3'(i), 0);
    add(1, OP_LOAD, 0, 8'h3C, 8'h3C, 0, 0, 0);
    add(1, OP_HOLD, 0, 8'h00, 8'h3C, 0, 0, 0);

    #2;
    chk("rst_q", q_out, 8'h00);
    chk("rst_s", s_out, 1'b0);
    chk("rst_cnt", bit_cnt, 3'd0);
    chk("rst_done", frame_done, 1'b0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      step8(vecs[i].en, vecs[i].op, vecs[i].s_in, vecs[i].d_in);
      chk($sformatf("v%0d_q", i), q_out, vecs[i].q);
      chk($sformatf("v%0d_s", i), s_out, vecs[i].s);
      chk($sformatf("v%0d_cnt", i), bit_cnt, vecs[i].cnt);
      chk($sformatf("v%0d_done", i), frame_done, vecs[i].done);
`ifdef UNIV_SHIFT_REG_PARITY_EN
      chk($sformatf("v%0d_par", i), parity, ^vecs[i].q);
`endif
    end

`ifdef UNIV_SHIFT_REG_PARITY_EN
    step8(1, OP_LOAD, 0, 8'h07);
    chk("par_load07", parity, 1'b1);
    step8(1, OP_SHL, 1, 8'h00);
    chk("par_shl_q", q_out, 8'h0F);
    chk("par_shl", parity, 1'b0);
`endif

    // Async reset mid-frame, between clock edges.
    step8(1, OP_LOAD, 0, 8'hFF);
    step8(1, OP_SHL, 1, 8'h00);
    step8(1, OP_SHL, 1, 8'h00);
    step8(1, OP_SHL, 1, 8'h00);
    chk("pre_arst_cnt", bit_cnt, 3'd3);
    chk("pre_arst_s", s_out, 1'b1);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_q", q_out, 8'h00);
    chk("arst_s", s_out, 1'b0);
    chk("arst_cnt", bit_cnt, 3'd0);
    chk("arst_done", frame_done, 1'b0);
    @(negedge clk); rst = 1'b0;

    // 4-bit frame: SHL 1,0,1,1 from reset.
    begin
      logic [3:0] bits;
      logic [3:0] exp_q [4];
      logic [1:0] exp_c [4];
      bits = 4'b1101;
      exp_q = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
      exp_c = '{2'd1, 2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 4; i++) begin
        en4 = 1'b1; op4 = OP_SHL; s_in4 = bits[i];
        @(posedge clk); #1;
        chk($sformatf("w4_q%0d", i), q4, exp_q[i]);
        chk($sformatf("w4_cnt%0d", i), cnt4, exp_c[i]);
        chk($sformatf("w4_done%0d", i), done4, (i == 3) ? 1'b1 : 1'b0);
      end
      op4 = OP_HOLD;
      @(posedge clk); #1;
      chk("w4_done_after", done4, 1'b0);
      chk("w4_q_hold", q4, 4'b1011);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
